// File: rtl/rr_sched4x16_pkg.sv
// Shared types and helpers for the 4-channel round-robin word scheduler.
// Holds the FSM state encoding, the data width and the rotate-priority pick function.
package rr_sched4x16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // First requesting channel after last, wrapping back to last itself; last+1 when no request.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last + 2'd1;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_sched4x16_if.sv
// Channel-side and output-side handshake bundle for rr_sched4x16.
// The scheduler takes the slave view; the producer/consumer side takes the master view.
interface rr_sched4x16_if
  import rr_sched4x16_pkg::*;
();
  logic [3:0]        req;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic [3:0]        ack;
  logic [1:0]        sel;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              y_ready;

  modport slave (
    input  req, a, b, c, d, y_ready,
    output ack, sel, y, y_valid
  );

  modport master (
    output req, a, b, c, d, y_ready,
    input  ack, sel, y, y_valid
  );
endinterface

// File: rtl/rr_sched4x16_mux4way16.sv
// Existing 4-way 16-bit word multiplexer, reused unchanged by the scheduler.
module mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/rr_sched4x16.sv
// Round-robin scheduler: picks one of four channel words per cycle into a single
// registered output slot with valid/ready handshake and a last-granted pointer.
module rr_sched4x16
  import rr_sched4x16_pkg::*;
#(
  parameter logic [1:0] RESET_PTR = 2'd3
) (
  input  logic           clk,
  input  logic           reset,
  rr_sched4x16_if.slave  bus
);

  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [1:0]        pick;
  logic [1:0]        sel_w;
  logic [DATA_W-1:0] mux_y;
  logic              load;

  // Reset forces the select to its post-reset value so nothing moves while reset is held.
  always_comb begin
    pick  = rr_pick(bus.req, last_q);
    sel_w = reset ? (RESET_PTR + 2'd1) : pick;
  end

  mux4way16 u_mux (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .sel (sel_w),
    .y   (mux_y)
  );

  always_comb begin
    load    = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    y_d     = y_q;
    if (!reset && (bus.req != 4'd0) && ((state_q == IDLE) || bus.y_ready)) begin
      load = 1'b1;
    end
    if (load) begin
      state_d = FULL;
      last_d  = sel_w;
      y_d     = mux_y;
    end else if ((state_q == FULL) && bus.y_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= RESET_PTR;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      y_q     <= y_d;
    end
  end

  assign bus.ack     = load ? onehot4(sel_w) : 4'd0;
  assign bus.sel     = sel_w;
  assign bus.y       = y_q;
  assign bus.y_valid = (state_q == FULL);

endmodule

// File: doc/rr_sched4x16.md
RR_SCHED4X16 -- requirements
Module: rr_sched4x16

Interface
REQ-001 Parameter RESET_PTR, default 2'd3: value of the last-granted pointer after reset, so channel (RESET_PTR+1) mod 4 has first priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-channel valid; bit i = channel i holds a word.
REQ-005 a, b, c, d  input  16 each  channel 0..3 data; stable while the matching req bit is high.
REQ-006 ack  output  4  one-hot consume strobe; ack[i]=1 means channel i's word is taken at this edge.
REQ-007 sel  output  2  channel index currently chosen by the scheduler; drives the mux select.
REQ-008 y  output  16  registered output word.
REQ-009 y_valid  output  1  y holds an unconsumed word.
REQ-010 y_ready  input  1  downstream accepts y at this edge when y_valid=1.

Function
REQ-011 Pointer last[1:0] records the most recently granted channel; search order: last+1, last+2, last+3, last (mod 4, 3 wraps to 0).
REQ-012 sel = first requesting channel in search order; with req=0, sel = last+1.
REQ-013 States: IDLE (y_valid=0) and FULL (y_valid=1).
REQ-014 load = (IDLE and req!=0) or (FULL and y_ready and req!=0).
REQ-015 On load: y <= word of channel sel (via mux), last <= sel, ack = one-hot(sel) in the same cycle, combinationally; state -> FULL.
REQ-016 ack = 0 whenever load = 0; never more than one ack bit high.
REQ-017 IDLE with req=0: stay IDLE, y holds its value.
REQ-018 FULL with y_ready=0: stay FULL, y, last and sel choice frozen except sel follows req changes; ack=0.
REQ-019 FULL with y_ready=1 and req=0: -> IDLE, y_valid <= 0, y holds.
REQ-020 Latency: req sampled high at edge k (IDLE) -> y/y_valid valid after edge k; full throughput of one word per cycle while y_ready=1 and req!=0.
REQ-021 A single requester is granted every cycle it requests (no forced skip); no requester waits more than 3 grants while continuously requesting.
REQ-022 req deasserting while not acked: word is simply not taken; no partial state.

Reset
REQ-023 On reset: state IDLE, y=16'h0000, y_valid=0, last=RESET_PTR, ack=0, sel=(RESET_PTR+1) mod 4.
REQ-024 Reset asserted mid-transfer discards the pending y word; first grant after release follows REQ-023 priority.
REQ-025 No output toggles while reset is high, regardless of req/y_ready.

Structure
REQ-026 Shared package holds state encoding (IDLE=1'b0, FULL=1'b1) and data width constant 16.
REQ-027 Data selection SHALL instantiate the existing mux4way16 sub-module (a,b,c,d,sel -> y); only the pick logic, pointer, FSM and output register are new.
REQ-028 No other sub-modules; pick logic is a rotate-priority encoder in this module.

Verification
REQ-029 Reset then req=4'b1111, a=1,b=2,c=3,d=4, y_ready=1 for 5 cycles -> y sequence 1,2,3,4,1; ack 0001,0010,0100,1000,0001.
REQ-030 req=4'b0100, c=16'hBEEF, y_ready=0 for 3 cycles -> one ack 0100, y=BEEF, y_valid stays 1, no further ack until y_ready=1.
REQ-031 last=3, req=4'b1001 continuously, y_ready=1 -> grants alternate 0,3,0,3; after last=0, sel=3.
REQ-032 FULL, y_ready=1, req=0 -> next cycle y_valid=0, y unchanged, ack=0.
REQ-033 Assert reset while y_valid=1, y=16'h1234 -> immediately y=0, y_valid=0; after release with req=4'b1111 first grant is channel 0.
REQ-034 RESET_PTR=1, reset, req=4'b1111 -> first grant channel 2.
